// File: rtl/scan_mux_pkg.sv
// Shared types and helpers for the scanning N:1 channel multiplexer.
// Holds the controller state encoding and the select-width helper.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    MANUAL_HOLD = 2'd1,
    SCAN        = 2'd2,
    DONE        = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/scan_mux_nx1_mux.sv
// Combinational channel extractor: picks one W-bit slice of the packed bus.
// An index past the last channel returns zero and raises out_of_range.
module mux_nx1
  import scan_mux_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 3,
  localparam int SW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic [N*W-1:0] in,
  input  logic [SW-1:0]  idx,
  output logic [W-1:0]   val,
  output logic           out_of_range
);

  always_comb begin
    val          = '0;
    out_of_range = (int'(idx) >= N);
    for (int k = 0; k < N; k++) begin
      if (int'(idx) == k) val = in[k*W +: W];
    end
  end

endmodule

// File: rtl/scan_mux_nx1.sv
// N:1 multiplexer with manual capture and an automatic valid/ready scan
// that reports the signed max/min of the channels seen in each scan.
module scan_mux_nx1
  import scan_mux_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 3,
  localparam int SW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           load,
  input  logic           start,
  output logic [W-1:0]   out,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           sel_err,
  output logic           scan_done,
  output logic [W-1:0]   max_val,
  output logic [W-1:0]   min_val
);

  state_t state, state_nxt;

  logic [SW-1:0]        mux_idx;
  logic [W-1:0]         mux_val;
  logic                 mux_oor;
  logic signed [W-1:0]  val_s;
  logic signed [W-1:0]  acc_max, acc_min;
  logic                 accept;
  logic                 present, first, clr_valid, enter_done, err;

  // Strict compares so that a tie keeps the value seen first.
  function automatic logic signed [W-1:0] pick_max(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
    return (b > a) ? b : a;
  endfunction

  function automatic logic signed [W-1:0] pick_min(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
    return (b < a) ? b : a;
  endfunction

  assign accept = out_valid && out_ready;
  assign val_s  = mux_val;

  // During a scan the mux always looks one channel ahead so the next value
  // is ready to load on the same edge that the current one is accepted.
  assign mux_idx = (state == SCAN) ? (out_ch + SW'(1)) :
                   (mode ? '0 : sel);

  mux_nx1 #(.N(N), .W(W)) u_mux (
    .in           (in),
    .idx          (mux_idx),
    .val          (mux_val),
    .out_of_range (mux_oor)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    present    = 1'b0;
    first      = 1'b0;
    clr_valid  = 1'b0;
    enter_done = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (mode) begin
          if (start) begin
            present   = 1'b1;
            first     = 1'b1;
            state_nxt = SCAN;
          end
        end else if (load) begin
          if (mux_oor) begin
            err = 1'b1;
          end else begin
            present   = 1'b1;
            state_nxt = MANUAL_HOLD;
          end
        end
      end
      MANUAL_HOLD: begin
        if (accept) begin
          clr_valid = 1'b1;
          state_nxt = IDLE;
        end
      end
      SCAN: begin
        if (accept) begin
          if (int'(out_ch) == N - 1) begin
            clr_valid  = 1'b1;
            enter_done = 1'b1;
            state_nxt  = DONE;
          end else begin
            present = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      scan_done <= 1'b0;
      max_val   <= '0;
      min_val   <= '0;
      acc_max   <= '0;
      acc_min   <= '0;
    end else begin
      sel_err   <= err;
      scan_done <= enter_done;
      if (present) begin
        out       <= mux_val;
        out_ch    <= mux_idx;
        out_valid <= 1'b1;
      end else if (clr_valid) begin
        out_valid <= 1'b0;
      end
      if (first) begin
        acc_max <= val_s;
        acc_min <= val_s;
      end else if (present && state == SCAN) begin
        acc_max <= pick_max(acc_max, val_s);
        acc_min <= pick_min(acc_min, val_s);
      end
      if (enter_done) begin
        max_val <= acc_max;
        min_val <= acc_min;
      end
    end
  end

endmodule

// File: tb/tb_scan_mux_nx1.sv
// Directed bench for scan_mux_nx1: manual capture, select errors, scans with
// and without back-pressure, mid-scan reset and an 8x4 max/min scan.
module tb_scan_mux_nx1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 5 x 3-bit instance
  logic [14:0] in5;
  logic [2:0]  sel5, out5, out_ch5, max5, min5;
  logic        mode5, load5, start5, ready5, valid5, err5, done5;

  // 8 x 4-bit instance
  logic [31:0] in8;
  logic [2:0]  sel8, out_ch8;
  logic [3:0]  out8, max8, min8;
  logic        mode8, load8, start8, ready8, valid8, err8, done8;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] exp5 [5] = '{3'b110, 3'b111, 3'b000, 3'b001, 3'b010};
  logic [3:0] exp8 [8] = '{4'b0111, 4'b1000, 4'b0011, 4'b0111,
                           4'b1000, 4'b0000, 4'b0001, 4'b0010};

  scan_mux_nx1 #(.N(5), .W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in(in5), .sel(sel5), .mode(mode5),
    .load(load5), .start(start5), .out(out5), .out_ch(out_ch5),
    .out_valid(valid5), .out_ready(ready5), .sel_err(err5),
    .scan_done(done5), .max_val(max5), .min_val(min5)
  );

  scan_mux_nx1 #(.N(8), .W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel8), .mode(mode8),
    .load(load8), .start(start8), .out(out8), .out_ch(out_ch8),
    .out_valid(valid8), .out_ready(ready8), .sel_err(err8),
    .scan_done(done8), .max_val(max8), .min_val(min8)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full scan on the 5-channel instance; optionally stalls one channel
  // while poking the manual-mode inputs, which must be ignored.
  task automatic run_scan(input int stall_ch, input int stall_n, input int exp_cyc);
    int cyc;
    mode5  = 1'b1;
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    cyc    = 1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("scan_out%0d", k), 32'(out5), 32'(exp5[k]));
      check($sformatf("scan_ch%0d", k), 32'(out_ch5), k);
      check($sformatf("scan_vld%0d", k), 32'(valid5), 1);
      if (k == stall_ch) begin
        ready5 = 1'b0;
        mode5  = 1'b0;
        load5  = 1'b1;
        sel5   = 3'd0;
        for (int j = 0; j < stall_n; j++) begin
          tick();
          cyc++;
          check("stall_out", 32'(out5), 32'(exp5[k]));
          check("stall_ch", 32'(out_ch5), k);
        end
        ready5 = 1'b1;
        mode5  = 1'b1;
        load5  = 1'b0;
      end
      tick();
      cyc++;
    end
    while (!done5 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("done_cycle", cyc, exp_cyc);
    check("done_pulse", 32'(done5), 1);
    check("done_vld", 32'(valid5), 0);
    check("max_val", 32'(max5), 32'(3'b010));
    check("min_val", 32'(min5), 32'(3'b110));
    tick();
    check("done_one_cycle", 32'(done5), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    in5    = {3'b010, 3'b001, 3'b000, 3'b111, 3'b110};
    sel5   = '0; mode5 = 1'b0; load5 = 1'b0; start5 = 1'b0; ready5 = 1'b1;
    in8    = {4'b0010, 4'b0001, 4'b0000, 4'b1000, 4'b0111, 4'b0011, 4'b1000, 4'b0111};
    sel8   = '0; mode8 = 1'b1; load8 = 1'b0; start8 = 1'b0; ready8 = 1'b1;
    tick();
    tick();
    check("rst_out", 32'(out5), 0);
    check("rst_vld", 32'(valid5), 0);
    check("rst_err", 32'(err5), 0);
    check("rst_done", 32'(done5), 0);
    rst_n = 1'b1;
    tick();

    // Manual capture of every channel
    for (int s = 0; s < 5; s++) begin
      sel5  = 3'(s);
      load5 = 1'b1;
      tick();
      load5 = 1'b0;
      check($sformatf("man_out%0d", s), 32'(out5), 32'(exp5[s]));
      check($sformatf("man_ch%0d", s), 32'(out_ch5), s);
      check($sformatf("man_vld%0d", s), 32'(valid5), 1);
      tick();
      check($sformatf("man_acc%0d", s), 32'(valid5), 0);
    end

    // Out-of-range selects
    for (int i = 0; i < 2; i++) begin
      sel5  = (i == 0) ? 3'd5 : 3'd7;
      load5 = 1'b1;
      tick();
      load5 = 1'b0;
      check("selerr_pulse", 32'(err5), 1);
      check("selerr_vld", 32'(valid5), 0);
      check("selerr_out", 32'(out5), 32'(3'b010));
      tick();
      check("selerr_clear", 32'(err5), 0);
    end

    run_scan(-1, 0, 6);
    run_scan(2, 3, 9);

    // Reset while channel 3 is presented
    mode5  = 1'b1;
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("pre_rst_ch", 32'(out_ch5), 3);
    rst_n = 1'b0;
    #1;
    check("arst_out", 32'(out5), 0);
    check("arst_ch", 32'(out_ch5), 0);
    check("arst_vld", 32'(valid5), 0);
    check("arst_max", 32'(max5), 0);
    check("arst_min", 32'(min5), 0);
    check("arst_done", 32'(done5), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_done", 32'(done5), 0);
    check("post_rst_vld", 32'(valid5), 0);
    run_scan(-1, 0, 6);

    // 8 x 4-bit scan with repeated extremes
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("s8_out%0d", k), 32'(out8), 32'(exp8[k]));
      check($sformatf("s8_ch%0d", k), 32'(out_ch8), k);
      tick();
    end
    check("s8_done", 32'(done8), 1);
    check("s8_max", 32'(max8), 32'(4'b0111));
    check("s8_min", 32'(min8), 32'(4'b1000));
    check("s8_err", 32'(err8), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_mux_nx1.md
SCAN_MUX_NX1 -- requirements
Module: scan_mux_nx1

Interface
REQ-001 The module SHALL have parameter N, default 5: number of input channels, N >= 2.
REQ-002 The module SHALL have parameter W, default 3: channel width in bits, two's-complement signed, W >= 2.
REQ-003 The module SHALL have derived localparam SW = max(1, clog2(N)): select width.
REQ-004 The module SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 The module SHALL have port in  input  N*W  packed channels; channel k occupies in[k*W+W-1 : k*W].
REQ-007 The module SHALL have port sel  input  SW  manual-mode channel select.
REQ-008 The module SHALL have port mode  input  1  0 = manual, 1 = scan.
REQ-009 The module SHALL have port load  input  1  manual-mode capture request.
REQ-010 The module SHALL have port start  input  1  scan-mode start request, sampled in IDLE only.
REQ-011 The module SHALL have port out  output  W  registered selected value.
REQ-012 The module SHALL have port out_ch  output  SW  channel index of out.
REQ-013 The module SHALL have port out_valid  output  1  out/out_ch hold a value not yet accepted.
REQ-014 The module SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-015 The module SHALL have port sel_err  output  1  one-cycle pulse: manual load with sel >= N.
REQ-016 The module SHALL have port scan_done  output  1  one-cycle pulse after the last scan channel is accepted.
REQ-017 The module SHALL have ports max_val, min_val  output  W each  signed max/min over the last completed scan.

Function
REQ-018 The FSM SHALL have states IDLE, MANUAL_HOLD, SCAN, DONE.
REQ-019 In IDLE with mode=0 and load=1, if sel < N: out <= channel[sel], out_ch <= sel, out_valid <= 1, next state MANUAL_HOLD, with 1-cycle latency.
REQ-020 In IDLE with mode=0, load=1, sel >= N: sel_err SHALL pulse 1 the next cycle, out/out_ch/out_valid unchanged, state stays IDLE (no X propagation).
REQ-021 MANUAL_HOLD SHALL hold out stable while out_valid && !out_ready; on acceptance, out_valid <= 0 and state returns to IDLE.
REQ-022 In IDLE with mode=1 and start=1, the state SHALL go to SCAN and present channel 0 with out_valid=1 the next cycle.
REQ-023 In SCAN, on acceptance of channel k < N-1, the block SHALL present channel k+1 the next cycle with no bubble; on acceptance of channel N-1, out_valid <= 0 and state goes to DONE.
REQ-024 In DONE for exactly one cycle: scan_done=1, max_val/min_val updated, then state returns to IDLE.
REQ-025 Max/min SHALL be accumulated by signed comparison of each presented channel value, with ties keeping the earlier value; the outputs change only in DONE.
REQ-026 In SCAN, a change on input in SHALL affect only channels not yet presented, because each channel value is registered when presented.
REQ-027 mode, load, start and sel SHALL be ignored outside IDLE; if start and load are both asserted in IDLE, mode alone decides.
REQ-028 out/out_ch SHALL never change while out_valid=1 and out_ready=0.

Reset
REQ-029 When rst_n=0, asynchronously: state=IDLE, out=0, out_ch=0, out_valid=0, sel_err=0, scan_done=0, max_val=0, min_val=0, internal accumulators cleared.
REQ-030 Reset asserted mid-scan or mid-hold SHALL abort the operation with no scan_done pulse; after release, the block waits in IDLE for a new request.

Structure
REQ-031 Package scan_mux_pkg SHALL hold the FSM state typedef (IDLE, MANUAL_HOLD, SCAN, DONE) and the clog2 helper function.
REQ-032 Sub-module mux_nx1 (combinational, parametrised N and W, index in, W-bit value plus out_of_range flag out) SHALL perform channel extraction, instantiated once.

Verification
REQ-033 The bench SHALL cover: N=5, W=3, channels {-2,-1,0,1,2} (110,111,000,001,010), mode=0, load with sel=0..4, out_ready=1 -> out equals 110,111,000,001,010 and out_ch=sel, each one cycle after load.
REQ-034 The bench SHALL cover: mode=0, sel=5 then 7 with load -> sel_err pulses once for each, and out_valid stays 0.
REQ-035 The bench SHALL cover: mode=1, start, out_ready=1 -> out -2,-1,0,1,2 on 5 consecutive cycles, then scan_done, max_val=010, min_val=110.
REQ-036 The bench SHALL cover: scan with out_ready low 3 cycles on channel 2 -> out holds 000 for 3 cycles, then the sequence resumes and scan_done comes 3 cycles later than in REQ-035.
REQ-037 The bench SHALL cover: rst_n driven low while channel 3 is presented -> all outputs are 0 immediately with no scan_done, and a new start rescans from channel 0.
REQ-038 The bench SHALL cover: N=8, W=4, channels {7,-8,...}, scan -> max_val=0111, min_val=1000, and ties resolve to the earlier channel.
